// File: rtl/flippy_lane.sv
// rtl/flippy_lane.sv - one falling-byte lane of the FlippyBit game
module flippy_lane #(
   parameter int          FALL_TICKS = 4,
   parameter int          ROWS       = 8,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       lane_reset,
   input  logic [7:0] switches,
   output logic [7:0] target,
   output logic [3:0] row,
   output logic       active,
   output logic       correct,
   output logic       game_over
);

   localparam int            TW        = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(FALL_TICKS - 1);
   localparam logic [3:0]    ROW_LAST  = 4'(ROWS - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HOLD = 3'd1,
      LOAD = 3'd2,
      FALL = 3'd3,
      HIT  = 3'd4,
      MISS = 3'd5
   } state_t;

   state_t        state;
   logic [7:0]    lfsr;
   logic [7:0]    sw_q;
   logic [TW-1:0] tick;

   // Galois LFSR, right shift, free-running in every state so each drop gets a fresh value
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr <= LFSR_SEED;
      end else begin
         lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
      end
   end

   // Register the switches once; every match decision looks at this copy
   always_ff @(posedge clock) begin
      if (reset) begin
         sw_q <= 8'h00;
      end else begin
         sw_q <= switches;
      end
   end

   // Lane state machine with registered outputs; lane_reset overrides every state
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         target    <= 8'h00;
         row       <= 4'd0;
         tick      <= '0;
         active    <= 1'b0;
         correct   <= 1'b0;
         game_over <= 1'b0;
      end else if (lane_reset) begin
         state     <= HOLD;
         row       <= 4'd0;
         tick      <= '0;
         active    <= 1'b0;
         correct   <= 1'b0;
         game_over <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state <= IDLE;
            end
            HOLD: begin
               state <= LOAD;
            end
            LOAD: begin
               // never spawn a target the player already matches; wait one LFSR step instead
               if (lfsr != sw_q) begin
                  target <= lfsr;
                  row    <= 4'd0;
                  tick   <= '0;
                  active <= 1'b1;
                  state  <= FALL;
               end
            end
            FALL: begin
               if (sw_q == target) begin
                  correct <= 1'b1;
                  active  <= 1'b0;
                  state   <= HIT;
               end else if (tick == TICK_LAST && row == ROW_LAST) begin
                  game_over <= 1'b1;
                  active    <= 1'b0;
                  state     <= MISS;
               end else if (tick == TICK_LAST) begin
                  tick <= '0;
                  row  <= row + 4'd1;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            HIT: begin
               state <= HIT;
            end
            MISS: begin
               state <= MISS;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_flippy_lane.sv
// tb/tb_flippy_lane.sv - directed bench for flippy_lane
module tb_flippy_lane;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       lane_reset = 1'b0;
   logic [7:0] switches = 8'h00;
   logic [7:0] target;
   logic [3:0] row;
   logic       active;
   logic       correct;
   logic       game_over;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] m_lfsr;
   logic [7:0] exp_target;

   flippy_lane #(
      .FALL_TICKS(4),
      .ROWS(8),
      .LFSR_SEED(8'hA5)
   ) dut (
      .clock(clock),
      .reset(reset),
      .lane_reset(lane_reset),
      .switches(switches),
      .target(target),
      .row(row),
      .active(active),
      .correct(correct),
      .game_over(game_over)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
   endfunction

   // reference LFSR stepped on the same edges as the lane
   always @(posedge clock) begin
      if (reset) m_lfsr <= 8'hA5;
      else       m_lfsr <= lfsr_next(m_lfsr);
   end

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_active"}, {7'd0, active}, 8'd0);
      check({tag, "_correct"}, {7'd0, correct}, 8'd0);
      check({tag, "_game_over"}, {7'd0, game_over}, 8'd0);
      check({tag, "_row"}, {4'd0, row}, 8'd0);
   endtask

   // pulse lane_reset one cycle and return on the first FALL cycle with the load checked
   task automatic start_drop(input string tag, output logic [7:0] loaded);
      lane_reset = 1'b1;
      step();
      lane_reset = 1'b0;
      check_idle_outputs({tag, "_hold"});
      step();
      check({tag, "_load_active"}, {7'd0, active}, 8'd0);
      loaded = m_lfsr;
      step();
      check({tag, "_fall_active"}, {7'd0, active}, 8'd1);
      check({tag, "_target"}, target, loaded);
      check({tag, "_row0"}, {4'd0, row}, 8'd0);
   endtask

   initial begin
      // reset state and idle without lane_reset
      step(3);
      reset = 1'b0;
      check_idle_outputs("rst");
      check("rst_target", target, 8'h00);
      for (int i = 0; i < 100; i++) begin
         step();
         if (i % 20 == 19) begin
            check_idle_outputs("idle");
            check("idle_target", target, 8'h00);
         end
      end

      // full drop to the bottom with switches at zero
      start_drop("drop1", exp_target);
      for (int i = 1; i < 32; i++) begin
         step();
         check("drop1_row", {4'd0, row}, 8'(i / 4));
         check("drop1_go_early", {7'd0, game_over}, 8'd0);
      end
      step();
      check("drop1_go", {7'd0, game_over}, 8'd1);
      check("drop1_go_active", {7'd0, active}, 8'd0);
      check("drop1_go_row", {4'd0, row}, 8'd7);
      step(10);
      check("drop1_go_held", {7'd0, game_over}, 8'd1);
      check("drop1_no_correct", {7'd0, correct}, 8'd0);
      check("drop1_target_kept", target, exp_target);

      // match at row 3
      start_drop("hit3", exp_target);
      step(12);
      check("hit3_row", {4'd0, row}, 8'd3);
      switches = target;
      step();
      check("hit3_not_yet", {7'd0, correct}, 8'd0);
      step();
      check("hit3_correct", {7'd0, correct}, 8'd1);
      check("hit3_row_frozen", {4'd0, row}, 8'd3);
      check("hit3_active", {7'd0, active}, 8'd0);
      step(50);
      check("hit3_held", {7'd0, correct}, 8'd1);
      check("hit3_held_row", {4'd0, row}, 8'd3);
      check("hit3_no_go", {7'd0, game_over}, 8'd0);
      switches = 8'h00;
      start_drop("reload", exp_target);
      check("reload_correct_clr", {7'd0, correct}, 8'd0);

      // match on the same edge the bottom would be reached
      step(30);
      switches = target;
      step();
      check("edge_row", {4'd0, row}, 8'd7);
      check("edge_active", {7'd0, active}, 8'd1);
      step();
      check("edge_correct", {7'd0, correct}, 8'd1);
      check("edge_no_go", {7'd0, game_over}, 8'd0);
      check("edge_row_hold", {4'd0, row}, 8'd7);
      switches = 8'h00;

      // abort at row 5 with a 3-cycle lane_reset
      start_drop("abort", exp_target);
      check("abort_clr_correct", {7'd0, correct}, 8'd0);
      step(20);
      check("abort_row5", {4'd0, row}, 8'd5);
      lane_reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_idle_outputs("abort_hold");
      end
      lane_reset = 1'b0;
      step();
      check_idle_outputs("abort_load");
      exp_target = m_lfsr;
      step();
      check("abort_restart_active", {7'd0, active}, 8'd1);
      check("abort_restart_row", {4'd0, row}, 8'd0);
      check("abort_restart_target", target, exp_target);

      // switches preloaded to the LFSR value seen in LOAD: LOAD stretches one cycle
      lane_reset = 1'b1;
      step();
      lane_reset = 1'b0;
      switches = lfsr_next(m_lfsr);
      step();
      step();
      check("pre_stretch_active", {7'd0, active}, 8'd0);
      exp_target = m_lfsr;
      step();
      check("pre_active", {7'd0, active}, 8'd1);
      check("pre_target", target, exp_target);
      check("pre_differs", {7'd0, target != switches}, 8'd1);
      step(2);
      check("pre_no_correct", {7'd0, correct}, 8'd0);

      // synchronous reset mid-fall, then a drop from the seed
      switches = 8'h00;
      step(6);
      reset = 1'b1;
      step();
      check_idle_outputs("midrst");
      check("midrst_target", target, 8'h00);
      reset = 1'b0;
      lane_reset = 1'b1;
      step();
      lane_reset = 1'b0;
      step(2);
      check("seed_active", {7'd0, active}, 8'd1);
      check("seed_target", target, 8'h75);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
